soft_mem_initiator: RTL

- Bridges a core-side valid/ready load/store request channel onto the BRAM-style memory port (ena/wea/addra/dina/douta) of the on-chip soft RAM.
- Translates byte addresses to word indices, checks range and alignment, and drives byte write strobes.
- Absorbs the memory's 1-cycle read latency and holds responses under backpressure.
- Sits between the core's data interface and the data RAM; one request in flight at a time, and it can accept a new request in the same cycle a response drains.

---
 rtl/soft_mem_initiator.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/soft_mem_initiator.sv
// soft_mem_initiator: bridges a valid/ready load/store request channel onto the
// BRAM-style port of the on-chip soft RAM. It decodes byte addresses into word
// indices, flags out-of-range or misaligned requests, and holds one response
// at a time. A new request can be accepted in the same cycle a response drains.
//
// Optional build macro: SOFT_MEM_INIT_RSP_REG_EN. When it is defined, read data
// is registered before the response is presented. This adds one cycle to reads
// and removes the combinational path from mem_douta_i to rsp_rdata_o.
//
//   state  | meaning
//   IDLE   | no response pending
//   RSP    | response pending on the response channel
//   RD_CAP | read issued last cycle, capturing mem_douta_i (macro builds only)
module soft_mem_initiator #(
  parameter int unsigned           WORD_SIZE_BYTE = 4,
  parameter int unsigned           SIZE_IN_KB     = 8,
  parameter int unsigned           ADDR_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  localparam int unsigned          DEPTH          = SIZE_IN_KB * 1024 / WORD_SIZE_BYTE,
  localparam int unsigned          MA_W           = $clog2(DEPTH) + 1,
  localparam int unsigned          DW             = WORD_SIZE_BYTE * 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [ADDR_WIDTH-1:0]     req_addr_i,
  input  logic                      req_we_i,
  input  logic [WORD_SIZE_BYTE-1:0] req_be_i,
  input  logic [DW-1:0]             req_wdata_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [DW-1:0]             rsp_rdata_o,
  output logic                      rsp_err_o,
  output logic                      mem_ena_o,
  output logic [WORD_SIZE_BYTE-1:0] mem_wea_o,
  output logic [MA_W-1:0]           mem_addra_o,
  output logic [DW-1:0]             mem_dina_o,
  input  logic [DW-1:0]             mem_douta_i
);

  localparam int unsigned           OFF_W      = $clog2(WORD_SIZE_BYTE);
  localparam logic [ADDR_WIDTH:0]   MEM_BYTES  = (ADDR_WIDTH + 1)'(SIZE_IN_KB * 1024);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(WORD_SIZE_BYTE - 1);

`ifdef SOFT_MEM_INIT_RSP_REG_EN
  typedef enum logic [1:0] {IDLE = 2'd0, RSP = 2'd1, RD_CAP = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, RSP = 2'd1} state_t;
`endif

  state_t                  state_q, state_d, state_after_accept;
  logic [ADDR_WIDTH-1:0]   off;
  logic                    err;
  logic                    accept;
  logic                    rd_ok;
  logic                    err_q;

  // The compare is one bit wider than the offset so that the memory size
  // cannot wrap when it equals 2**ADDR_WIDTH.
  assign off = req_addr_i - BASE_ADDR;
  assign err = (req_addr_i < BASE_ADDR)
             | ({1'b0, off} >= MEM_BYTES)
             | (|(off & ALIGN_MASK));

  // Ready is forced low while reset is held.
  assign req_ready_o = rst_ni & ((state_q == IDLE) | ((state_q == RSP) & rsp_ready_i));
  assign accept      = req_valid_i & req_ready_o;
  assign rd_ok       = accept & ~err & ~req_we_i;

  // A write with no byte enables completes without touching memory.
  // The index is zeroed for errored requests so that its MSB stays 0.
  assign mem_ena_o   = accept & ~err & ~(req_we_i & (req_be_i == '0));
  assign mem_wea_o   = (mem_ena_o & req_we_i) ? req_be_i : '0;
  assign mem_addra_o = (accept & ~err) ? off[OFF_W +: MA_W] : '0;
  assign mem_dina_o  = accept ? req_wdata_i : '0;

`ifdef SOFT_MEM_INIT_RSP_REG_EN
  assign state_after_accept = rd_ok ? RD_CAP : RSP;
`else
  assign state_after_accept = RSP;
`endif

  // Next-state logic; a response drain may coincide with a new accept.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = state_after_accept;
      end
      RSP: begin
        if (rsp_ready_i) state_d = accept ? state_after_accept : IDLE;
      end
`ifdef SOFT_MEM_INIT_RSP_REG_EN
      RD_CAP: state_d = RSP;
`endif
      default: state_d = IDLE;
    endcase
  end

  // State register and the error flag latched when a request is accepted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) err_q <= err;
    end
  end

  assign rsp_valid_o = (state_q == RSP);
  assign rsp_err_o   = (state_q == RSP) & err_q;

`ifdef SOFT_MEM_INIT_RSP_REG_EN
  logic [DW-1:0] rdata_q;

  // Writes and errors clear the register; reads fill it in RD_CAP.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (state_q == RD_CAP) begin
      rdata_q <= mem_douta_i;
    end else if (accept) begin
      rdata_q <= '0;
    end
  end

  assign rsp_rdata_o = (state_q == RSP) ? rdata_q : '0;
`else
  logic rd_q;

  // Records whether the pending response belongs to a successful read.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q <= 1'b0;
    end else if (accept) begin
      rd_q <= rd_ok;
    end
  end

  // The BRAM output holds because no new access is issued until this drains.
  assign rsp_rdata_o = ((state_q == RSP) & rd_q) ? mem_douta_i : '0;
`endif

endmodule
